// File: rtl/verilated_fixtures_pkg.sv
// verilated_fixtures_pkg: shared snapshot state, default sizes and bus slicing for the counter bank.
package verilated_fixtures_pkg;
   typedef enum logic {SNAP_IDLE, SNAP_HELD} snap_state_e;
   localparam int DEF_WIDTH       = 8;
   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CYCLE_WIDTH = 32;
   function automatic int slice_lo(input int ch, input int width);
      return ch * width;
   endfunction
endpackage

// File: rtl/fixture_counter_channel.sv
// fixture_counter_channel: one up/down counter with load and terminal-count pulse.
// VERILATED_COUNTER_SATURATE_EN adds a sat input that clamps at the limits instead of wrapping.
module fixture_counter_channel
   import verilated_fixtures_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             sync_rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
`ifdef VERILATED_COUNTER_SATURATE_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   logic [WIDTH-1:0] count_q, count_d, step;
   logic             tc_q, tc_d, at_lim;
   assign at_lim = up ? &count_q : ~|count_q;
   assign step   = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
   assign count  = count_q;
   assign tc     = tc_q;
`ifdef VERILATED_COUNTER_SATURATE_EN
   logic step_lim;
   assign step_lim = up ? &step : ~|step;
`endif
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = load_value;
      end else if (en) begin
`ifdef VERILATED_COUNTER_SATURATE_EN
         // saturating channels pulse only on the edge that first lands on the limit
         count_d = (sat && at_lim) ? count_q : step;
         tc_d    = sat ? (!at_lim && step_lim) : at_lim;
`else
         count_d = step;
         tc_d    = at_lim;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end
endmodule

// File: rtl/verilated_counter_bank.sv
// verilated_counter_bank: CHANNELS counters, free-running cycle counter and atomic snapshot handshake.
// VERILATED_COUNTER_SATURATE_EN adds the per-channel sat input.
module verilated_counter_bank
   import verilated_fixtures_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
   input  logic                      clk,
   input  logic                      sync_rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       up,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_value,
`ifdef VERILATED_COUNTER_SATURATE_EN
   input  logic [CHANNELS-1:0]       sat,
`endif
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       tc,
   output logic [CYCLE_WIDTH-1:0]    cycles,
   input  logic                      snap_req,
   input  logic                      snap_ack,
   output logic                      snap_valid,
   output logic [CHANNELS*WIDTH-1:0] snap_data
);
   snap_state_e                state_q, state_d;
   logic [CHANNELS*WIDTH-1:0]  snap_data_q, snap_data_d;
   logic [CYCLE_WIDTH-1:0]     cycles_q, cycles_d;
   logic                       capture;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      fixture_counter_channel #(.WIDTH(WIDTH)) u_ch (
         .clk        (clk),
         .sync_rst   (sync_rst),
         .en         (en[i]),
         .up         (up[i]),
         .load       (load[i]),
         .load_value (load_value[slice_lo(i, WIDTH) +: WIDTH]),
`ifdef VERILATED_COUNTER_SATURATE_EN
         .sat        (sat[i]),
`endif
         .count      (count[slice_lo(i, WIDTH) +: WIDTH]),
         .tc         (tc[i])
      );
   end
   // count holds pre-update register values, so all channels are captured from the same edge
   assign capture    = snap_req && (state_q == SNAP_IDLE || snap_ack);
   assign snap_valid = state_q == SNAP_HELD;
   assign snap_data  = snap_data_q;
   assign cycles     = cycles_q;
   always_comb begin
      cycles_d    = cycles_q + CYCLE_WIDTH'(1);
      snap_data_d = capture ? count : snap_data_q;
      state_d     = capture ? SNAP_HELD : (snap_ack ? SNAP_IDLE : state_q);
   end
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q     <= SNAP_IDLE;
         snap_data_q <= '0;
         cycles_q    <= '0;
      end else begin
         state_q     <= state_d;
         snap_data_q <= snap_data_d;
         cycles_q    <= cycles_d;
      end
   end
endmodule

// File: tb/tb_verilated_counter_bank.sv
// tb_verilated_counter_bank: directed vectors for wrap, priority, snapshot and (optionally) saturation.
module tb_verilated_counter_bank;
   localparam int W = 8, C = 4, CW = 32;
   logic          clk = 1'b0;
   logic          sync_rst;
   logic [C-1:0]  en, up, load;
   logic [C*W-1:0] load_value, count, snap_data;
   logic [C-1:0]  tc;
   logic [CW-1:0] cycles;
   logic          snap_req, snap_ack, snap_valid;
`ifdef VERILATED_COUNTER_SATURATE_EN
   logic [C-1:0]  sat;
`endif
   int checks = 0, errors = 0;

   verilated_counter_bank #(.WIDTH(W), .CHANNELS(C), .CYCLE_WIDTH(CW)) dut (
      .clk        (clk),
      .sync_rst   (sync_rst),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
`ifdef VERILATED_COUNTER_SATURATE_EN
      .sat        (sat),
`endif
      .count      (count),
      .tc         (tc),
      .cycles     (cycles),
      .snap_req   (snap_req),
      .snap_ack   (snap_ack),
      .snap_valid (snap_valid),
      .snap_data  (snap_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      sync_rst = 1'b1; en = '1; up = '1; load = '0; load_value = '0;
      snap_req = 1'b0; snap_ack = 1'b0;
`ifdef VERILATED_COUNTER_SATURATE_EN
      sat = '0;
`endif
      tick(); tick();
      check("rst_count", 64'(count), 64'h0);
      check("rst_cycles", 64'(cycles), 64'h0);
      check("rst_tc", 64'(tc), 64'h0);
      check("rst_valid", 64'(snap_valid), 64'h0);
      check("rst_snap", 64'(snap_data), 64'h0);
      sync_rst = 1'b0; en = '0;
      tick();
      check("cycles_1", 64'(cycles), 64'h1);
      load = 4'b0001; load_value = 32'h0000_00FE;
      tick();
      check("ld_fe", 64'(count[7:0]), 64'hFE);
      load = '0; en = 4'b0001; up = 4'b0001;
      tick();
      check("up_ff", 64'(count[7:0]), 64'hFF);
      check("up_ff_tc", 64'(tc), 64'h0);
      tick();
      check("up_wrap", 64'(count[7:0]), 64'h00);
      check("up_wrap_tc", 64'(tc), 64'h1);
      en = '0;
      tick();
      check("hold_tc", 64'(tc), 64'h0);
      check("hold_cnt", 64'(count[7:0]), 64'h00);
      check("cycles_5", 64'(cycles), 64'h5);
      en = 4'b0010; up = 4'b0000;
      tick();
      check("dn_wrap", 64'(count[15:8]), 64'hFF);
      check("dn_wrap_tc", 64'(tc), 64'h2);
      load = 4'b0010; load_value = 32'h0000_5500;
      tick();
      check("ld_prio", 64'(count[15:8]), 64'h55);
      check("ld_prio_tc", 64'(tc), 64'h0);
      load = 4'b1111; en = '0; load_value = 32'h0109_0703;
      tick();
      check("ld_all", 64'(count), 64'h0109_0703);
      load = '0; en = '1; up = '1; snap_req = 1'b1;
      tick();
      check("snap_valid", 64'(snap_valid), 64'h1);
      check("snap_data", 64'(snap_data), 64'h0109_0703);
      check("snap_run", 64'(count), 64'h020A_0804);
      snap_req = 1'b0;
      tick();
      check("snap_hold", 64'(snap_data), 64'h0109_0703);
      check("run_on", 64'(count), 64'h030B_0905);
      snap_req = 1'b1;
      tick();
      check("req_ignored", 64'(snap_data), 64'h0109_0703);
      check("req_ign_valid", 64'(snap_valid), 64'h1);
      snap_req = 1'b0; snap_ack = 1'b1;
      tick();
      check("ack_idle", 64'(snap_valid), 64'h0);
      check("ack_retain", 64'(snap_data), 64'h0109_0703);
      snap_ack = 1'b0; snap_req = 1'b1;
      tick();
      check("cap2", 64'(snap_data), 64'h060E_0C08 - 64'h0101_0101);
      snap_ack = 1'b1;
      tick();
      check("recap_valid", 64'(snap_valid), 64'h1);
      check("recap_data", 64'(snap_data), 64'h060E_0C08);
      check("recap_count", 64'(count), 64'h070F_0D09);
      snap_ack = 1'b0; snap_req = 1'b0; sync_rst = 1'b1;
      tick();
      check("rst_held_valid", 64'(snap_valid), 64'h0);
      check("rst_held_data", 64'(snap_data), 64'h0);
      check("rst_held_count", 64'(count), 64'h0);
      sync_rst = 1'b0; en = '0;
`ifdef VERILATED_COUNTER_SATURATE_EN
      sat = 4'b0100; load = 4'b0100; load_value = 32'h00FD_0000;
      tick();
      load = '0; en = 4'b0100; up = 4'b0100;
      tick();
      check("sat_fe", 64'(count[23:16]), 64'hFE);
      check("sat_fe_tc", 64'(tc), 64'h0);
      tick();
      check("sat_ff", 64'(count[23:16]), 64'hFF);
      check("sat_ff_tc", 64'(tc), 64'h4);
      tick();
      check("sat_hold1", 64'(count[23:16]), 64'hFF);
      check("sat_hold1_tc", 64'(tc), 64'h0);
      tick();
      check("sat_hold2", 64'(count[23:16]), 64'hFF);
      check("sat_hold2_tc", 64'(tc), 64'h0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/verilated_counter_bank.md
# verilated_counter_bank

Parametrised multi-channel counter fixture for the Verilator harness, successor to the single-width fixture counters. It provides CHANNELS independent counters of WIDTH bits. Each counter supports enable, direction, parallel load and terminal-count signalling, plus a free-running cycle counter and a snapshot handshake that captures all channels atomically. Harness tests use it to exercise clocking, synchronous reset, multi-word buses and ready/valid style handshakes.

## Interface
- WIDTH, 8, bits per channel counter (2..64)
- CHANNELS, 4, number of counter channels (1..16)
- CYCLE_WIDTH, 32, width of free-running cycle counter
- clk  in  1  sole clock, all state updates on posedge
- sync_rst  in  1  synchronous reset, active-high; one clock, synchronous active-high reset (fixed)
- en  in  CHANNELS  per-channel count enable
- up  in  CHANNELS  per-channel direction: 1 increment, 0 decrement
- load  in  CHANNELS  per-channel parallel load strobe
- load_value  in  CHANNELS*WIDTH  load data, channel i at [i*WIDTH +: WIDTH]
- count  out  CHANNELS*WIDTH  current counter values, same packing
- tc  out  CHANNELS  terminal-count pulse, one cycle
- cycles  out  CYCLE_WIDTH  free-running cycle count
- snap_req  in  1  snapshot request
- snap_ack  in  1  consumer accepts snapshot
- snap_valid  out  1  snapshot held and valid
- snap_data  out  CHANNELS*WIDTH  captured counter values

## Operation
- Reset: count, tc, cycles, snap_data all 0; snap_valid 0. Reset overrides every other input.
- Per-channel priority each edge: sync_rst > load > en. load sets count to load_value and clears tc. en&up gives count+1; en&!up gives count-1. !en holds.
- Arithmetic is modulo 2^WIDTH. Up from all-ones wraps to 0; down from 0 wraps to all-ones. In both cases tc is 1 for the cycle following the wrapping edge, otherwise 0.
- cycles increments every non-reset edge and wraps modulo 2^CYCLE_WIDTH; it has no tc.
- Snapshot: two states, IDLE (snap_valid=0) and HELD (snap_valid=1).
  - IDLE & snap_req: capture, go to HELD.
  - HELD & snap_ack & !snap_req: go to IDLE; snap_data retained.
  - HELD & snap_ack & snap_req: recapture, remain HELD.
  - HELD & !snap_ack: snap_req is ignored, and snap_data is stable.
- Capture takes the count values present before the capturing edge, i.e. pre-update values, all channels from the same edge.
- Reset mid-handshake returns to IDLE and clears snap_data.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Count/load effect is visible one cycle after the sampling edge. tc is aligned with the wrapped count value.
- Snapshot latency: snap_req at edge N gives snap_valid=1 and snap_data=count(N-1 state) after edge N.
- snap_ack is sampled only while snap_valid=1.

## Configuration
- VERILATED_COUNTER_SATURATE_EN defined: adds input sat (CHANNELS wide).
  - A channel with sat=1 clamps instead of wrapping: holds all-ones when counting up and 0 when counting down.
  - tc pulses on the cycle the channel first reaches the limit; it stays 0 while held at the limit.
- Macro undefined: no sat port; all channels always wrap.

## Structure
- Package verilated_fixtures_pkg holds:
  - the snapshot state enum (SNAP_IDLE, SNAP_HELD);
  - default parameter constants;
  - a function computing the per-channel slice offset.
- Sub-module fixture_counter_channel implements one counter (en/up/load/tc, optional sat). It is instantiated CHANNELS times by generate.
- Top level holds the cycle counter and the snapshot FSM.

## Test plan
- Reset: drive sync_rst high for 2 cycles with en all 1 -> count=0, cycles=0, tc=0, snap_valid=0. After release, cycles=1 one edge later.
- Up wrap, ch0, WIDTH=8: load 0xFE, then en=1 up=1 for 2 cycles -> 0xFF, then 0x00 with tc[0]=1 for exactly one cycle.
- Down wrap plus priority, ch1: count 0, en=1 up=0 -> 0xFF with tc[1]=1. Assert load=1 (value 0x55) together with en -> 0x55, no decrement.
- Snapshot with channels at 3,7,9,1: pulse snap_req -> snap_valid=1, snap_data={1,9,7,3}.
  - Counters keep running while snap_data holds.
  - snap_req while unacked is ignored.
  - snap_ack returns to IDLE.
- Simultaneous ack and req while HELD -> snap_valid stays 1 and snap_data updates to the current counts. Reset while HELD -> snap_valid=0, snap_data=0.
- With VERILATED_COUNTER_SATURATE_EN and sat[2]=1: load 0xFD, count up 4 cycles -> 0xFE, 0xFF, 0xFF, 0xFF, with tc[2]=1 only on the first 0xFF.
